// File: rtl/max7219_rx.sv
// MAX7219 receive-side mirror: synchronizes the 3-wire serial interface,
// collects 16-bit command frames, writes a MAX7219-style register file on
// LOAD rising edge and decodes the digit segment patterns back to hex.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | LOAD high; SCLK edges ignored, waiting for LOAD to fall
// SHIFT  | LOAD low; each SCLK rise shifts in one DIN bit
// COMMIT | LOAD just rose; judge bit count and write the frame

module max7219_regfile (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic [63:0] digits_flat,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        display_test
);

  logic [63:0] digits_q, digits_d;
  logic [7:0]  decode_q, decode_d;
  logic [3:0]  intensity_q, intensity_d;
  logic [2:0]  scan_q, scan_d;
  logic        shutdown_q, shutdown_d;
  logic        test_q, test_d;

  // Address decode of a committed frame; 0x0, 0xD and 0xE write nothing.
  always_comb begin
    digits_d    = digits_q;
    decode_d    = decode_q;
    intensity_d = intensity_q;
    scan_d      = scan_q;
    shutdown_d  = shutdown_q;
    test_d      = test_q;
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (wr_addr == 4'(i + 1)) digits_d[8*i +: 8] = wr_data;
      end
      case (wr_addr)
        4'h9:    decode_d    = wr_data;
        4'hA:    intensity_d = wr_data[3:0];
        4'hB:    scan_d      = wr_data[2:0];
        4'hC:    shutdown_d  = wr_data[0];
        4'hF:    test_d      = wr_data[0];
        default: ;
      endcase
    end
  end

  // Register file storage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digits_q    <= '0;
      decode_q    <= '0;
      intensity_q <= '0;
      scan_q      <= '0;
      shutdown_q  <= 1'b0;
      test_q      <= 1'b0;
    end else begin
      digits_q    <= digits_d;
      decode_q    <= decode_d;
      intensity_q <= intensity_d;
      scan_q      <= scan_d;
      shutdown_q  <= shutdown_d;
      test_q      <= test_d;
    end
  end

  assign digits_flat  = digits_q;
  assign decode_mode  = decode_q;
  assign intensity    = intensity_q;
  assign scan_limit   = scan_q;
  assign shutdown_n   = shutdown_q;
  assign display_test = test_q;

endmodule

module max7219_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sclk_in,
  input  logic        din_in,
  input  logic        load_in,
  output logic [63:0] digits_flat,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        display_test,
  output logic [31:0] hex_value,
  output logic [7:0]  hex_unknown,
  output logic        frame_valid,
  output logic [15:0] frame_word,
  output logic        err_len
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic                   load_prev_q, load_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [15:0]            shift_q, shift_d;
  logic [4:0]             count_q, count_d;
  logic [15:0]            frame_word_q, frame_word_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   err_len_q, err_len_d;
  logic                   wr_en;
  logic                   load_s, sclk_s, din_s;
  logic                   load_rise, load_fall, sclk_rise;
  logic [4:0]             seg_res;

  assign load_s    = load_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign load_rise = load_s & ~load_prev_q;
  assign load_fall = ~load_s & load_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  // Synchronizer chains plus one delayed copy for edge detection.
  always_comb begin
    load_sync_d = {load_sync_q[SYNC_STAGES-2:0], load_in};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
    din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], din_in};
    load_prev_d = load_s;
    sclk_prev_d = sclk_s;
  end

  // Frame FSM: shifting, bit counting and commit decision.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    count_d       = count_q;
    frame_word_d  = frame_word_q;
    frame_valid_d = 1'b0;
    err_len_d     = 1'b0;
    wr_en         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_fall) begin
          state_d = ST_SHIFT;
          count_d = '0;
        end
      end
      ST_SHIFT: begin
        // A coincident SCLK rise loses to the LOAD rise.
        if (load_rise) begin
          state_d = ST_COMMIT;
        end else if (sclk_rise) begin
          shift_d = {shift_q[14:0], din_s};
          count_d = (count_q == 5'd31) ? count_q : count_q + 5'd1;
        end
      end
      ST_COMMIT: begin
        state_d   = ST_IDLE;
        err_len_d = (count_q != 5'd16);
        // Overlong frames keep the last 16 bits, as the real part does.
        if (count_q >= 5'd16) begin
          wr_en         = 1'b1;
          frame_word_d  = shift_q;
          frame_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      load_sync_q   <= '1;
      sclk_sync_q   <= '0;
      din_sync_q    <= '0;
      load_prev_q   <= 1'b1;
      sclk_prev_q   <= 1'b0;
      shift_q       <= '0;
      count_q       <= '0;
      frame_word_q  <= '0;
      frame_valid_q <= 1'b0;
      err_len_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_sync_q   <= load_sync_d;
      sclk_sync_q   <= sclk_sync_d;
      din_sync_q    <= din_sync_d;
      load_prev_q   <= load_prev_d;
      sclk_prev_q   <= sclk_prev_d;
      shift_q       <= shift_d;
      count_q       <= count_d;
      frame_word_q  <= frame_word_d;
      frame_valid_q <= frame_valid_d;
      err_len_q     <= err_len_d;
    end
  end

  max7219_regfile u_regfile (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_addr      (shift_q[11:8]),
    .wr_data      (shift_q[7:0]),
    .digits_flat  (digits_flat),
    .decode_mode  (decode_mode),
    .intensity    (intensity),
    .scan_limit   (scan_limit),
    .shutdown_n   (shutdown_n),
    .display_test (display_test)
  );

  // Returns {unknown, nibble} for a 7-segment pattern (DP already dropped).
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h7E:   seg_decode = 5'h00;
      7'h30:   seg_decode = 5'h01;
      7'h6D:   seg_decode = 5'h02;
      7'h79:   seg_decode = 5'h03;
      7'h33:   seg_decode = 5'h04;
      7'h5B:   seg_decode = 5'h05;
      7'h5F:   seg_decode = 5'h06;
      7'h70:   seg_decode = 5'h07;
      7'h7F:   seg_decode = 5'h08;
      7'h7B:   seg_decode = 5'h09;
      7'h7D:   seg_decode = 5'h0A;
      7'h1F:   seg_decode = 5'h0B;
      7'h0D:   seg_decode = 5'h0C;
      7'h3D:   seg_decode = 5'h0D;
      7'h4F:   seg_decode = 5'h0E;
      7'h47:   seg_decode = 5'h0F;
      default: seg_decode = 5'h10;
    endcase
  endfunction

  // Per-digit readback: raw nibble in code-B mode, glyph match otherwise.
  always_comb begin
    hex_value   = '0;
    hex_unknown = '0;
    seg_res     = '0;
    for (int i = 0; i < 8; i++) begin
      seg_res = seg_decode(digits_flat[8*i +: 7]);
      if (decode_mode[i]) begin
        hex_value[4*i +: 4] = digits_flat[8*i +: 4];
      end else begin
        hex_value[4*i +: 4] = seg_res[3:0];
        hex_unknown[i]      = seg_res[4];
      end
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_word  = frame_word_q;
  assign err_len     = err_len_q;

endmodule

// File: tb/tb_max7219_rx.sv
// Bench for max7219_rx: drives serial frames and checks every cycle against
// a register-image model, plus literal expectations after each scenario.

module tb_max7219_rx;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset_n, sclk_in, din_in, load_in;
  logic [63:0] digits_flat;
  logic [7:0]  decode_mode, hex_unknown;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown_n, display_test, frame_valid, err_len;
  logic [31:0] hex_value;
  logic [15:0] frame_word;

  max7219_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sclk_in      (sclk_in),
    .din_in       (din_in),
    .load_in      (load_in),
    .digits_flat  (digits_flat),
    .decode_mode  (decode_mode),
    .intensity    (intensity),
    .scan_limit   (scan_limit),
    .shutdown_n   (shutdown_n),
    .display_test (display_test),
    .hex_value    (hex_value),
    .hex_unknown  (hex_unknown),
    .frame_valid  (frame_valid),
    .frame_word   (frame_word),
    .err_len      (err_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_seen = 1'b0;
  int fv_cnt = 0;
  int err_cnt = 0;

  // Model: expected register image and pending LOAD commits.
  typedef struct {
    int          due;
    int          n;
    logic [15:0] w;
  } pend_t;
  pend_t pq[$];

  logic [7:0]  m_dig [8];
  logic [7:0]  m_dm;
  logic [3:0]  m_int;
  logic [2:0]  m_sl;
  logic        m_sd, m_dt, m_fv, m_err;
  logic [15:0] m_fw;
  logic [6:0]  glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h7D, 7'h1F, 7'h0D, 7'h3D, 7'h4F, 7'h47};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_dig[i] = 8'h00;
    m_dm = 0; m_int = 0; m_sl = 0; m_sd = 0; m_dt = 0; m_fw = 0;
    pq.delete();
  endtask

  task automatic model_commit(input int n, input logic [15:0] w);
    int a;
    m_err = (n != 16);
    if (n < 16) return;
    m_fv = 1'b1;
    m_fw = w;
    a = int'(w[11:8]);
    if (a >= 1 && a <= 8) m_dig[a-1] = w[7:0];
    else if (a == 9)  m_dm  = w[7:0];
    else if (a == 10) m_int = w[3:0];
    else if (a == 11) m_sl  = w[2:0];
    else if (a == 12) m_sd  = w[0];
    else if (a == 15) m_dt  = w[0];
  endtask

  function automatic logic [63:0] exp_digits();
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = m_dig[i];
    return r;
  endfunction

  // Returns {unknown[7:0], hex[31:0]} from the model image.
  function automatic logic [39:0] exp_hex();
    logic [31:0] hv = '0;
    logic [7:0]  hu = '0;
    for (int i = 0; i < 8; i++) begin
      if (m_dm[i]) begin
        hv[4*i +: 4] = m_dig[i][3:0];
      end else begin
        hu[i] = 1'b1;
        for (int g = 0; g < 16; g++) begin
          if (glyph[g] == m_dig[i][6:0]) begin
            hv[4*i +: 4] = 4'(g);
            hu[i] = 1'b0;
          end
        end
      end
    end
    return {hu, hv};
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !reset_n;
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [39:0] eh;
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (!reset_n) model_reset();
    while (pq.size() > 0 && pq[0].due <= cyc) begin
      model_commit(pq[0].n, pq[0].w);
      void'(pq.pop_front());
    end
    if (frame_valid === 1'b1) fv_cnt++;
    if (err_len === 1'b1) err_cnt++;
    if (reset_n || rst_seen) begin
      eh = exp_hex();
      chk("digits_flat", digits_flat, exp_digits());
      chk("decode_mode", decode_mode, m_dm);
      chk("intensity", intensity, m_int);
      chk("scan_limit", scan_limit, m_sl);
      chk("shutdown_n", shutdown_n, m_sd);
      chk("display_test", display_test, m_dt);
      chk("frame_word", frame_word, m_fw);
      chk("frame_valid", frame_valid, m_fv);
      chk("err_len", err_len, m_err);
      chk("hex_value", hex_value, eh[31:0]);
      chk("hex_unknown", hex_unknown, eh[39:32]);
    end
  end

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int b = n - 1; b >= 0; b--) begin
      din_in = bits[b];
      wait_cyc(4);
      sclk_in = 1'b1;
      wait_cyc(4);
      sclk_in = 1'b0;
    end
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    pend_t p;
    load_in = 1'b0;
    wait_cyc(4);
    shift_bits(bits, n);
    wait_cyc(4);
    load_in = 1'b1;
    p.due = cyc + SYNC + 2;
    p.n   = n;
    p.w   = bits[15:0];
    pq.push_back(p);
    wait_cyc(10);
  endtask

  initial begin
    reset_n = 1'b0; load_in = 1'b1; sclk_in = 1'b0; din_in = 1'b0;
    wait_cyc(5);
    chk("rst_shutdown", shutdown_n, 1'b0);
    chk("rst_hex_unknown", hex_unknown, 8'hFF);
    reset_n = 1'b1;
    wait_cyc(6);

    send(32'h0C01, 16);
    chk("lit_shutdown", shutdown_n, 1'b1);
    chk("lit_fw_0c01", frame_word, 16'h0C01);
    chk("lit_digits_zero", digits_flat, 64'h0);

    send(32'h0A03, 16);
    send(32'h0B07, 16);
    send(32'h0900, 16);
    chk("lit_intensity3", intensity, 4'h3);
    chk("lit_scan7", scan_limit, 3'h7);

    send(32'h0830, 16);
    send(32'h076D, 16);
    send(32'h0679, 16);
    send(32'h0533, 16);
    send(32'h045B, 16);
    send(32'h035F, 16);
    send(32'h0270, 16);
    send(32'h017F, 16);
    chk("lit_hex_12345678", hex_value, 32'h12345678);
    chk("lit_unknown_none", hex_unknown, 8'h00);

    send(32'h0180, 16);
    chk("lit_dp_unknown", hex_unknown, 8'h01);
    chk("lit_dp_hex", hex_value, 32'h12345670);

    send(32'h09FF, 16);
    send(32'h0205, 16);
    chk("lit_decode_ff", decode_mode, 8'hFF);
    chk("lit_codeb_hex", hex_value, 32'h0D93BF50);

    send(32'h0ABC, 12);
    chk("lit_short_nochange", intensity, 4'h3);
    send(32'h50A0F, 20);
    chk("lit_long_intensity", intensity, 4'hF);
    chk("lit_long_fw", frame_word, 16'h0A0F);

    send(32'h0D55, 16);
    chk("lit_ignored_fw", frame_word, 16'h0D55);
    chk("lit_ignored_int", intensity, 4'hF);

    // Reset in the middle of a frame, then a fresh frame.
    load_in = 1'b0;
    wait_cyc(4);
    shift_bits(32'h0C, 8);
    reset_n = 1'b0; load_in = 1'b1; sclk_in = 1'b0; din_in = 1'b0;
    wait_cyc(4);
    reset_n = 1'b1;
    wait_cyc(8);
    send(32'h0F01, 16);
    chk("lit_rst_shutdown", shutdown_n, 1'b0);
    chk("lit_rst_test", display_test, 1'b1);
    chk("lit_fv_total", 32'(fv_cnt), 32'd18);
    chk("lit_err_total", 32'(err_cnt), 32'd2);

    wait_cyc(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/max7219_rx.md
Name: max7219_rx

Overview:
Receive-side model of the MAX7219 3-wire serial interface. Oversamples SCLK/DIN/LOAD with the system clock, shifts 16-bit command frames, and commits them on LOAD rising edge into a MAX7219-compatible register file. Also decodes the segment patterns back to hex nibbles. Used as an on-chip loopback/checker for the display driver and as a display mirror for debug readback.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronizers on sclk_in/din_in/load_in (min 2)

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous, active-low reset
sclk_in  input  1  serial clock from driver; data sampled on rising edge
din_in  input  1  serial data, MSB first
load_in  input  1  frame strobe; low during shift, rising edge commits
digits_flat  output  64  digit registers, digit i at [8i+7:8i] (address i+1)
decode_mode  output  8  register 0x9
intensity  output  4  register 0xA[3:0]
scan_limit  output  3  register 0xB[2:0]
shutdown_n  output  1  register 0xC[0]; 0 = shutdown
display_test  output  1  register 0xF[0]
hex_value  output  32  decoded nibble per digit, digit i at [4i+3:4i]
hex_unknown  output  8  bit i set when digit i pattern is not a recognised glyph
frame_valid  output  1  one-cycle pulse per committed frame
frame_word  output  16  last committed frame (held)
err_len  output  1  one-cycle pulse when LOAD rises with bit count != 16

Behaviour:
- Reset: synchronous, active-low reset_n on clk. All registers 0: digits_flat, decode_mode, intensity, scan_limit, shutdown_n, display_test, frame_word, frame_valid, err_len. Shift reg and bit count 0. Synchronizer chains load 1 for load, 0 for sclk/din. State IDLE.
- Reset asserted mid-frame: the partial frame is discarded and no commit occurs. After release, the block waits for load_s to be high, then low, before shifting.
- Inputs pass through SYNC_STAGES flops (load_s, sclk_s, din_s). Edges are detected against one extra registered copy.
- Timing requirement on the driver: SCLK high and low phases, and DIN setup before the SCLK rise, each >= SYNC_STAGES+1 clk periods.
- FSM states:
  - IDLE (load_s=1): sclk edges ignored. load_s falling -> SHIFT, bit count cleared.
  - SHIFT: each sclk_s rising edge does shift_reg <= {shift_reg[14:0], din_s} and count <= count+1, saturating at 31. load_s rising -> COMMIT.
  - COMMIT (1 cycle): evaluate frame, then -> IDLE.
- Simultaneous events: an sclk_s rising edge detected in the same cycle as a load_s rising edge is not shifted.
- Frame rules in COMMIT:
  - count >= 16: accept shift_reg (the last 16 bits, matching MAX7219 behaviour).
  - count < 16: discard; no register write.
  - err_len pulses in COMMIT whenever count != 16.
- Accepted frame:
  - frame_word <= shift_reg; frame_valid high for exactly one cycle, in the cycle after COMMIT.
  - Address = shift_reg[11:8]; shift_reg[15:12] is don't-care.
  - Address decode: 0x0 no-op; 0x1-0x8 write digit (addr-1) = data[7:0]; 0x9 decode_mode = data; 0xA intensity = data[3:0]; 0xB scan_limit = data[2:0]; 0xC shutdown_n = data[0]; 0xF display_test = data[0]; 0xD/0xE ignored (frame_valid still pulses).
  - Register outputs update on the same edge as frame_valid rising. Total latency from load_in rising to outputs: SYNC_STAGES+2 clk edges.
- hex_value / hex_unknown: combinational from the digit registers and decode_mode.
  - If decode_mode[i]=1: nibble = digit[i][3:0], unknown=0.
  - Else: bit7 (DP) is masked, and the pattern is matched on [6:0]. 0x7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 7D->A, 1F->B, 0D->C, 3D->D, 4F->E, 47->F.
  - Any other pattern -> nibble 0, unknown=1. The reset pattern 0x00 therefore reports unknown=1.

Test Plan:
- After reset, shift 0x0C01 with LOAD low then raise LOAD -> shutdown_n=1, frame_word=0x0C01, one frame_valid pulse, no err_len; all other outputs remain 0.
- Shift 0x0A03, 0x0B07, 0x0900 -> intensity=3, scan_limit=7, decode_mode=0x00.
- Send digits 8..1 with segment codes for 1,2,3,4,5,6,7,8 (0x30..0x7F) -> hex_value=0x12345678, hex_unknown=0x00. Then send 0x0180 -> digit0=0x80, hex_unknown[0]=1, hex_value[3:0]=0.
- Send 0x09FF, then 0x0205 -> decode_mode=0xFF, hex_value[7:4]=5, unknown=0.
- Short/long frames: 12 bits then LOAD rise -> no register change, err_len pulse, no frame_valid. 20 bits whose last 16 are 0x0A0F -> intensity=0xF, err_len and frame_valid both pulse.
- Assert reset_n=0 after 8 bits of 0x0C01, then release and send full 0x0F01 -> shutdown_n stays 0, display_test=1, exactly one frame_valid.
